l2_mem_responder: RTL and testbench

Memory-side responder for the L2 cache's 128-bit line interface. It accepts the single outstanding line read or write that the cache initiator issues on mem_read/mem_write/mem_addr/mem_wdata. After a fixed, parameterised latency it completes the access against an internal line array and answers with a one-cycle mem_ready pulse. It serves as the simulation/FPGA backing store behind the L2 and carries traffic counters and a protocol-error flag for verification.

---
 rtl/l2_mem_responder.sv | 115 +++++++++++
 tb/tb_l2_mem_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/l2_mem_responder.sv
// l2_mem_responder: backing-store line memory behind the L2 cache.
// Takes one line read or write at a time and completes it LATENCY cycles
// after acceptance with a single-cycle mem_ready pulse. It also keeps
// saturating traffic counters and a sticky protocol-error flag.
module l2_mem_responder #(
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 8
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              protocol_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Request captured on the acceptance edge. The full address is kept so
  // that a change while the access is in flight can be flagged.
  typedef struct packed {
    logic              is_rd;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t state, state_nxt;
  req_t   req;
  logic [7:0] cnt;

  // The line array is not reset, so its contents survive proc_reset.
  logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];

  logic                  req_one, req_both, done, held_bad;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  ready_d, err_d, rd_inc, wr_inc;
  logic [7:0]            cnt_d;

  assign req_one  = mem_read ^ mem_write;
  assign req_both = mem_read & mem_write;
  assign idx      = req.addr[DEPTH_LOG2-1:0];
  assign done     = (state == BUSY) && (cnt == 8'd0);
  // The initiator must keep the same request and address asserted until mem_ready.
  assign held_bad = (req.is_rd ? !mem_read : !mem_write) || (mem_addr != req.addr);

  // State register
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic. Requests are not sampled in RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_one) state_nxt = BUSY;
      BUSY:    if (cnt == 8'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and the latency counter
  always_comb begin
    ready_d = done;
    rd_inc  = done && req.is_rd;
    wr_inc  = done && !req.is_rd;
    err_d   = protocol_err
            | ((state == IDLE) && req_both)
            | ((state == BUSY) && held_bad);
    cnt_d   = cnt;
    if (state == IDLE && req_one)      cnt_d = LAT_M1;
    else if (state == BUSY && cnt != 0) cnt_d = cnt - 8'd1;
  end

  // Registered outputs, latched request and counter; all cleared by reset
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      cnt          <= '0;
      req          <= '0;
      mem_ready    <= 1'b0;
      mem_rdata    <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
      protocol_err <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      mem_ready    <= ready_d;
      protocol_err <= err_d;
      if (state == IDLE && req_one)
        req <= '{is_rd: mem_read, addr: mem_addr, wdata: mem_wdata};
      if (rd_inc) begin
        mem_rdata <= mem_q[idx];
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
      if (wr_inc && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

  // Array write on completion; reset has already forced IDLE, so an
  // in-flight write is dropped
  always_ff @(posedge clk) begin
    if (done && !req.is_rd && !proc_reset) mem_q[idx] <= req.wdata;
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: the driver pushes the expected
// completion (data, cycle, counts), and a monitor pops and checks it on
// every mem_ready.
module tb_l2_mem_responder;
  localparam int LAT = 8;

  logic         clk = 1'b0, run = 1'b0;
  logic         proc_reset, mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready, protocol_err;
  logic [15:0]  rd_count, wr_count;

  l2_mem_responder #(.ADDR_W(28), .LINE_W(128), .DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .rd_count(rd_count), .wr_count(wr_count),
    .protocol_err(protocol_err));

  typedef struct {
    logic [127:0] rdata;
    int           cyc;
    logic [15:0]  rc;
    logic [15:0]  wc;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0, miscompares = 0, cyc = 0;
  logic [15:0]  exp_rc = 0, exp_wc = 0;
  logic [127:0] last_rd = 0;

  localparam logic [127:0] D0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D2 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_5678;
  localparam logic [127:0] DA = {16{8'hAA}};

  initial forever begin #5; if (run) clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a request and push its expected completion. dly is the number
  // of edges until acceptance: 1 from IDLE, 2 when issued during RESP.
  task automatic issue(input bit rd, input logic [27:0] a, input logic [127:0] wd,
                       input logic [127:0] exp_data, input int dly);
    exp_t e;
    mem_read = rd; mem_write = !rd; mem_addr = a; mem_wdata = wd;
    if (rd) begin
      if (exp_rc != 16'hFFFF) exp_rc++;
      last_rd = exp_data;
    end else if (exp_wc != 16'hFFFF) exp_wc++;
    e.rdata = last_rd; e.cyc = cyc + dly + LAT; e.rc = exp_rc; e.wc = exp_wc;
    sb.push_back(e);
  endtask

  // Bounded wait for mem_ready; returns #1 into the RESP cycle
  task automatic wait_ready();
    for (int i = 0; i < 4 * LAT + 10; i++) begin
      tick(1);
      if (mem_ready) return;
    end
    chk("ready_timeout", 128'(mem_ready), 128'd1);
  endtask

  task automatic drop_to_idle();
    mem_read = 0; mem_write = 0;
    tick(1);
  endtask

  // Monitor: every mem_ready must match the head of the scoreboard
  initial begin
    bit   prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (proc_reset) prev = 0;
      else begin
        if (mem_ready) begin
          chk("ready_width", 128'(prev), 128'd0);
          if (sb.size() == 0) chk("unexpected_ready", 128'(mem_ready), 128'd0);
          else begin
            e = sb.pop_front();
            chk("rdata", mem_rdata, e.rdata);
            chk("ready_cycle", 128'(cyc), 128'(e.cyc));
            chk("rd_count", 128'(rd_count), 128'(e.rc));
            chk("wr_count", 128'(wr_count), 128'(e.wc));
          end
        end
        prev = mem_ready;
      end
    end
  end

  initial begin
    proc_reset = 1; mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0;
    // 1: async reset with the clock stopped
    #1;
    chk("rst_ready", 128'(mem_ready), 128'd0);
    chk("rst_rdata", mem_rdata, 128'd0);
    chk("rst_rd_count", 128'(rd_count), 128'd0);
    chk("rst_wr_count", 128'(wr_count), 128'd0);
    chk("rst_err", 128'(protocol_err), 128'd0);
    run = 1;
    tick(2); proc_reset = 0; tick(1);

    // 2: write then read line 5
    issue(0, 28'h5, D0, 0, 1);  wait_ready(); drop_to_idle();
    issue(1, 28'h5, 0, D0, 1);  wait_ready(); drop_to_idle();

    // 3: preload B, then write A and switch straight to reads of B and A
    issue(0, 28'h20, D2, 0, 1); wait_ready(); drop_to_idle();
    issue(0, 28'h10, D1, 0, 1); wait_ready();
    issue(1, 28'h20, 0, D2, 2); wait_ready();
    issue(1, 28'h10, 0, D1, 2); wait_ready(); drop_to_idle();

    // 4: aliasing modulo 256 lines
    issue(0, 28'h105, DA, 0, 1); wait_ready();
    issue(1, 28'h5, 0, DA, 2);   wait_ready(); drop_to_idle();

    // 5: both requests high in IDLE
    mem_read = 1; mem_write = 1; mem_addr = 28'h33;
    tick(3);
    chk("both_err", 128'(protocol_err), 128'd1);
    chk("both_rd_count", 128'(rd_count), 128'(exp_rc));
    chk("both_wr_count", 128'(wr_count), 128'(exp_wc));
    mem_read = 0; mem_write = 0;
    issue(1, 28'h105, 0, DA, 1); wait_ready(); drop_to_idle();
    chk("err_sticky", 128'(protocol_err), 128'd1);

    // 6: reset during a write's BUSY phase discards it
    issue(0, 28'h7, 128'h2, 0, 1); wait_ready(); drop_to_idle();
    mem_write = 1; mem_addr = 28'h7; mem_wdata = 128'h1;
    tick(4);
    proc_reset = 1; exp_rc = 0; exp_wc = 0; last_rd = 0;
    #1;
    chk("mid_rst_wr_count", 128'(wr_count), 128'd0);
    chk("mid_rst_err", 128'(protocol_err), 128'd0);
    chk("mid_rst_ready", 128'(mem_ready), 128'd0);
    mem_write = 0;
    tick(2); proc_reset = 0;
    tick(LAT + 4);
    issue(1, 28'h7, 0, 128'h2, 1); wait_ready(); drop_to_idle();
    chk("final_wr_count", 128'(wr_count), 128'd0);
    chk("sb_empty", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
